// File: rtl/gift_req_scheduler.sv
// Shares one GIFT-128 core between NUM_REQ requesters: round-robin job intake, core key/data
// sequencing with key-reload skipping, completion watchdog and per-requester result return.
module gift_req_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                   inClk,
  input  logic                   inRstN,
  input  logic [NUM_REQ-1:0]     inReqValid,
  output logic [NUM_REQ-1:0]     outReqReady,
  input  logic [NUM_REQ*128-1:0] inReqKey,
  input  logic [NUM_REQ*128-1:0] inReqData,
  input  logic [NUM_REQ-1:0]     inReqNewKey,
  output logic [NUM_REQ-1:0]     outRspValid,
  input  logic [NUM_REQ-1:0]     inRspReady,
  output logic [127:0]           outRspData,
  output logic                   outRspErr,
  output logic                   outCoreKeyWr,
  output logic [127:0]           outCoreKey,
  output logic                   outCoreDataWr,
  output logic [127:0]           outCoreData,
  input  logic                   inCoreBusy,
  input  logic [127:0]           inCoreData,
  output logic                   outIdle
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, KEY, DATA, WAITHI, WAITLO, RSP} stateE;

  stateE            state, stateNext;
  logic [1:0]       rstSync;
  logic             rstN;
  logic [PTR_W-1:0] rrPtr, grantSel, cand, reqIdx, owner;
  logic             grantFound, selNewKey;
  logic [127:0]     selKey, selData, keyReg, dataReg, storedKey;
  logic             keyOwnerValid;
  logic [7:0]       waitCnt;
  logic             accept, keyReuse, waiting, coreDone, waitTimeout;

  // NOTE: the reset enters asynchronously but leaves on a clock edge, so no flop sees a release mid-cycle.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) rstSync <= 2'b00;
    else         rstSync <= {rstSync[0], 1'b1};
  end
  assign rstN = rstSync[1];

  // Round-robin: first valid requester at or after rrPtr, wrapping.
  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    grantFound = 1'b0;
    grantSel   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(rrPtr) + k) % NUM_REQ);
      if (!grantFound && inReqValid[cand]) begin
        grantFound = 1'b1;
        grantSel   = cand;
      end
    end
  end

  always_comb begin
    selKey    = '0;
    selData   = '0;
    selNewKey = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grantSel == PTR_W'(k)) begin
        selKey    = inReqKey[128*k +: 128];
        selData   = inReqData[128*k +: 128];
        selNewKey = inReqNewKey[k];
      end
    end
  end

  assign accept      = (state == IDLE) && grantFound && rstN;
  assign keyReuse    = keyOwnerValid && (owner == grantSel) && !selNewKey && (selKey == storedKey);
  assign waiting     = (state == WAITHI) || (state == WAITLO);
  assign coreDone    = (state == WAITLO) && !inCoreBusy;
  assign waitTimeout = waiting && !coreDone && (waitCnt == TIMEOUT_CNT);

  always_comb begin
    stateNext     = state;
    outReqReady   = '0;
    outRspValid   = '0;
    outCoreKeyWr  = 1'b0;
    outCoreDataWr = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          outReqReady[grantSel] = 1'b1;
          stateNext = keyReuse ? DATA : KEY;
        end
      end
      KEY: begin
        outCoreKeyWr = 1'b1;
        stateNext    = DATA;
      end
      DATA: begin
        outCoreDataWr = 1'b1;
        stateNext     = WAITHI;
      end
      WAITHI: begin
        if (waitTimeout)     stateNext = RSP;
        else if (inCoreBusy) stateNext = WAITLO;
      end
      WAITLO: begin
        if (coreDone || waitTimeout) stateNext = RSP;
      end
      RSP: begin
        outRspValid[reqIdx] = 1'b1;
        if (inRspReady[reqIdx]) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential blocks use non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge inClk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge inClk or negedge rstN) begin
    if (!rstN) begin
      rrPtr         <= '0;
      reqIdx        <= '0;
      owner         <= '0;
      keyReg        <= '0;
      dataReg       <= '0;
      storedKey     <= '0;
      keyOwnerValid <= 1'b0;
      waitCnt       <= '0;
      outRspData    <= '0;
      outRspErr     <= 1'b0;
    end else begin
      if (accept) begin
        keyReg  <= selKey;
        dataReg <= selData;
        reqIdx  <= grantSel;
        rrPtr   <= (grantSel == PTR_W'(NUM_REQ - 1)) ? '0 : grantSel + 1'b1;
      end
      if (state == KEY) begin
        storedKey     <= keyReg;
        owner         <= reqIdx;
        keyOwnerValid <= 1'b1;
      end
      if (state == DATA)
        waitCnt <= '0;
      else if (waiting && waitCnt != 8'hFF)
        waitCnt <= waitCnt + 1'b1;
      // A timed-out core may hold a corrupted key, so the next job must reload it.
      if (coreDone) begin
        outRspData <= inCoreData;
        outRspErr  <= 1'b0;
      end else if (waitTimeout) begin
        outRspData    <= '0;
        outRspErr     <= 1'b1;
        keyOwnerValid <= 1'b0;
      end
    end
  end

  assign outCoreKey  = keyReg;
  assign outCoreData = dataReg;
  assign outIdle     = (state == IDLE);

endmodule
